multicycle_ctrl: RTL and testbench

- Multicycle sequencer for the LEGv8 datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with the instruction and data memories.
- It drives the same control bus as the single-cycle control unit (reg2loc, seu, aluSrc, aluOp, memWr, memToReg, regWr, pcSrc), plus per-state write strobes for PC and IR.
- It keeps a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/insn_decode.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 143 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, instruction classes, control codes and opcode match patterns
// for the LEGv8 multicycle controller.
package ctrl_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
    typedef enum logic [2:0] {CL_R, CL_I, CL_LD, CL_ST, CL_B, CL_CBZ, CL_CBNZ, CL_ILL} cls_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] SEU_ALU = 2'b00;
    localparam logic [1:0] SEU_D   = 2'b01;
    localparam logic [1:0] SEU_B   = 2'b10;
    localparam logic [1:0] SEU_CB  = 2'b11;

    localparam logic [10:0] M_FULL = 11'b11111111111;
    localparam logic [10:0] M_I    = 11'b11111111110;
    localparam logic [10:0] M_CB   = 11'b11111111000;
    localparam logic [10:0] M_B    = 11'b11111100000;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_ANDI = 11'b10010010000;
    localparam logic [10:0] OP_ORRI = 11'b10110010000;

    function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/insn_decode.sv
// insn_decode: combinational opcode to instruction class and static control fields.
module insn_decode
    import ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output cls_e        cls,
    output logic        reg2loc,
    output logic [1:0]  seu,
    output logic        alu_src,
    output logic [2:0]  alu_op
);

    logic i_add, i_sub, i_and, i_orr, i_addi, i_subi, i_andi, i_orri;
    logic i_ld, i_st, i_b, i_cbz, i_cbnz;

    assign i_add  = op_match(opcode, OP_ADD,  M_FULL);
    assign i_sub  = op_match(opcode, OP_SUB,  M_FULL);
    assign i_and  = op_match(opcode, OP_AND,  M_FULL);
    assign i_orr  = op_match(opcode, OP_ORR,  M_FULL);
    assign i_ld   = op_match(opcode, OP_LDUR, M_FULL);
    assign i_st   = op_match(opcode, OP_STUR, M_FULL);
    assign i_b    = op_match(opcode, OP_B,    M_B);
    assign i_cbz  = op_match(opcode, OP_CBZ,  M_CB);
    assign i_cbnz = op_match(opcode, OP_CBNZ, M_CB);
    assign i_addi = op_match(opcode, OP_ADDI, M_I);
    assign i_subi = op_match(opcode, OP_SUBI, M_I);
    assign i_andi = op_match(opcode, OP_ANDI, M_I);
    assign i_orri = op_match(opcode, OP_ORRI, M_I);

    assign cls = (i_add | i_sub | i_and | i_orr)     ? CL_R    :
                 (i_addi | i_subi | i_andi | i_orri) ? CL_I    :
                 i_ld                                ? CL_LD   :
                 i_st                                ? CL_ST   :
                 i_b                                 ? CL_B    :
                 i_cbz                               ? CL_CBZ  :
                 i_cbnz                              ? CL_CBNZ : CL_ILL;

    assign reg2loc = i_st | i_cbz | i_cbnz;
    assign seu     = (i_ld | i_st) ? SEU_D : i_b ? SEU_B : (i_cbz | i_cbnz) ? SEU_CB : SEU_ALU;
    assign alu_src = i_addi | i_subi | i_andi | i_orri | i_ld | i_st;
    assign alu_op  = (i_sub | i_subi) ? ALU_SUB :
                     (i_and | i_andi) ? ALU_AND :
                     (i_orr | i_orri) ? ALU_ORR :
                     (i_cbz | i_cbnz) ? ALU_PASSB : ALU_ADD;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes and retire counter.
// Define MCTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes instead of retiring them as NOPs.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [10:0]      opcode,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             bus_reg2loc,
    output logic [1:0]       bus_seu,
    output logic             bus_aluSrc,
    output logic [2:0]       bus_aluOp,
    output logic             bus_memWr,
    output logic             bus_memToReg,
    output logic             bus_regWr,
    output logic             bus_pcSrc,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic             req_pend_q, req_pend_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire, fields_on;
    cls_e             cls;
    logic             dec_reg2loc, dec_alu_src;
    logic [1:0]       dec_seu;
    logic [2:0]       dec_alu_op;

    insn_decode u_dec (
        .opcode  (opcode),
        .cls     (cls),
        .reg2loc (dec_reg2loc),
        .seu     (dec_seu),
        .alu_src (dec_alu_src),
        .alu_op  (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            req_pend_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_pend_q <= req_pend_d;
            retired_q  <= retired_d;
        end
    end

`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_pend_d = 1'b0;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        bus_memWr  = 1'b0;
        bus_regWr  = 1'b0;
        bus_pcSrc  = 1'b0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        case (state_q)
            FETCH: begin
                // rst_n gating keeps the request low while reset is held
                imem_req   = rst_n & (en | req_pend_q);
                req_pend_d = imem_req & ~imem_ack;
                ir_wr      = imem_req & imem_ack;
                state_d    = ir_wr ? DECODE : FETCH;
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                case (cls)
                    CL_R, CL_I:   state_d = WB;
                    CL_LD, CL_ST: state_d = MEM;
                    CL_B, CL_CBZ, CL_CBNZ: begin
                        pc_wr     = 1'b1;
                        bus_pcSrc = (cls == CL_B) ? 1'b1 : (cls == CL_CBZ) ? zero : ~zero;
                        retire    = 1'b1;
                        state_d   = FETCH;
                    end
                    default: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = HALT;
`else
                        pc_wr     = 1'b1;
                        retire    = 1'b1;
                        state_d   = FETCH;
`endif
                    end
                endcase
            end
            MEM: begin
                dmem_req  = 1'b1;
                bus_memWr = cls == CL_ST;
                pc_wr     = dmem_ack & (cls == CL_ST);
                retire    = pc_wr;
                state_d   = !dmem_ack ? MEM : (cls == CL_ST) ? FETCH : WB;
            end
            WB: begin
                bus_regWr = 1'b1;
                pc_wr     = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = state_q;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    assign fields_on    = state_q inside {DECODE, EXEC, MEM, WB};
    assign bus_reg2loc  = fields_on & dec_reg2loc;
    assign bus_seu      = fields_on ? dec_seu : 2'b00;
    assign bus_aluSrc   = fields_on & dec_alu_src;
    assign bus_aluOp    = fields_on ? dec_alu_op : ALU_ADD;
    assign bus_memToReg = fields_on & (cls == CL_LD);
    assign retired      = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scenario tests for the multicycle controller.
module tb_multicycle_ctrl;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, zero = 1'b0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [10:0] opcode = 11'b0;
    logic        imem_req, dmem_req, ir_wr, pc_wr, bus_reg2loc, bus_aluSrc;
    logic        bus_memWr, bus_memToReg, bus_regWr, bus_pcSrc, illegal;
    logic [1:0]  bus_seu;
    logic [2:0]  bus_aluOp;
    logic [2:0]  retired;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .bus_reg2loc(bus_reg2loc), .bus_seu(bus_seu),
        .bus_aluSrc(bus_aluSrc), .bus_aluOp(bus_aluOp), .bus_memWr(bus_memWr),
        .bus_memToReg(bus_memToReg), .bus_regWr(bus_regWr), .bus_pcSrc(bus_pcSrc),
        .retired(retired), .illegal(illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [10:0] op);
        opcode = op; en = 1'b1; imem_ack = 1'b1;
        step();
        en = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        total++; if (retired !== 3'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        total++; if ({ir_wr, pc_wr, bus_regWr, illegal} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {ir_wr, pc_wr, bus_regWr, illegal}); end
        step();
        rst_n = 1'b1; en = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_imem_req got=%b exp=0", imem_req); end
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_imem_req2 got=%b exp=0", imem_req); end
    endtask

    task automatic test_add();
        opcode = 11'b10001011000; en = 1'b1; imem_ack = 1'b1;
        #1;
        total++; if ({imem_req, ir_wr} !== 2'b11) begin bad++; $display("FAIL add_fetch got=%b exp=11", {imem_req, ir_wr}); end
        step();
        en = 1'b0; imem_ack = 1'b0;
        #1;
        total++; if ({ir_wr, bus_regWr, bus_aluSrc, bus_aluOp} !== 6'b000000) begin bad++; $display("FAIL add_decode got=%b exp=000000", {ir_wr, bus_regWr, bus_aluSrc, bus_aluOp}); end
        step();
        total++; if ({pc_wr, bus_regWr} !== 2'b00) begin bad++; $display("FAIL add_exec got=%b exp=00", {pc_wr, bus_regWr}); end
        step();
        total++; if ({bus_regWr, pc_wr, bus_pcSrc, retired} !== 6'b110000) begin bad++; $display("FAIL add_wb got=%b exp=110000", {bus_regWr, pc_wr, bus_pcSrc, retired}); end
        step();
        total++; if (retired !== 3'd1) begin bad++; $display("FAIL add_retired got=%0d exp=1", retired); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL add_no_req got=%b exp=0", imem_req); end
    endtask

    task automatic test_ldur();
        fetch(11'b11111000010);
        #1;
        total++; if ({bus_seu, bus_aluSrc, bus_aluOp} !== 6'b011000) begin bad++; $display("FAIL ldur_fields got=%b exp=011000", {bus_seu, bus_aluSrc, bus_aluOp}); end
        step();
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL ldur_exec_dreq got=%b exp=0", dmem_req); end
        step();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            total++; if ({dmem_req, bus_regWr, bus_memWr} !== 3'b100) begin bad++; $display("FAIL ldur_mem%0d got=%b exp=100", i, {dmem_req, bus_regWr, bus_memWr}); end
            step();
        end
        dmem_ack = 1'b0;
        #1;
        total++; if ({bus_memToReg, bus_regWr, pc_wr, dmem_req} !== 4'b1110) begin bad++; $display("FAIL ldur_wb got=%b exp=1110", {bus_memToReg, bus_regWr, pc_wr, dmem_req}); end
        step();
        total++; if (retired !== 3'd2) begin bad++; $display("FAIL ldur_retired got=%0d exp=2", retired); end
    endtask

    task automatic test_stur();
        fetch(11'b11111000000);
        #1;
        total++; if ({bus_reg2loc, bus_seu, bus_memToReg} !== 4'b1010) begin bad++; $display("FAIL stur_fields got=%b exp=1010", {bus_reg2loc, bus_seu, bus_memToReg}); end
        step();
        step();
        total++; if ({dmem_req, bus_memWr, pc_wr, bus_regWr} !== 4'b1100) begin bad++; $display("FAIL stur_mem0 got=%b exp=1100", {dmem_req, bus_memWr, pc_wr, bus_regWr}); end
        step();
        dmem_ack = 1'b1;
        #1;
        total++; if ({dmem_req, bus_memWr, pc_wr, bus_pcSrc, bus_regWr} !== 5'b11100) begin bad++; $display("FAIL stur_ack got=%b exp=11100", {dmem_req, bus_memWr, pc_wr, bus_pcSrc, bus_regWr}); end
        step();
        dmem_ack = 1'b0;
        #1;
        total++; if ({retired, bus_regWr, bus_memWr} !== 5'b01100) begin bad++; $display("FAIL stur_done got=%b exp=01100", {retired, bus_regWr, bus_memWr}); end
    endtask

    task automatic test_branch();
        logic [10:0] ops [3] = '{11'b10110100101, 11'b10110101011, 11'b00010111111};
        logic [1:0]  seus [3] = '{2'b11, 2'b11, 2'b10};
        logic        srcs [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            fetch(ops[i]);
            zero = 1'b1;
            #1;
            total++; if (bus_seu !== seus[i]) begin bad++; $display("FAIL br%0d_seu got=%b exp=%b", i, bus_seu, seus[i]); end
            if (i < 2) begin
                total++; if ({bus_aluOp, bus_reg2loc} !== 4'b1001) begin bad++; $display("FAIL br%0d_cb_fields got=%b exp=1001", i, {bus_aluOp, bus_reg2loc}); end
            end
            step();
            total++; if ({pc_wr, bus_pcSrc} !== {1'b1, srcs[i]}) begin bad++; $display("FAIL br%0d_exec got=%b exp=%b", i, {pc_wr, bus_pcSrc}, {1'b1, srcs[i]}); end
            step();
            zero = 1'b0;
            total++; if (retired !== 3'(4 + i)) begin bad++; $display("FAIL br%0d_retired got=%0d exp=%0d", i, retired, 4 + i); end
        end
    endtask

    task automatic test_en_drop();
        opcode = 11'b10110010001; en = 1'b1; imem_ack = 1'b0;
        #1;
        total++; if ({imem_req, ir_wr} !== 2'b10) begin bad++; $display("FAIL hold_req0 got=%b exp=10", {imem_req, ir_wr}); end
        step();
        en = 1'b0;
        #1;
        total++; if ({imem_req, ir_wr} !== 2'b10) begin bad++; $display("FAIL hold_req1 got=%b exp=10", {imem_req, ir_wr}); end
        step();
        imem_ack = 1'b1;
        #1;
        total++; if ({imem_req, ir_wr} !== 2'b11) begin bad++; $display("FAIL hold_ack got=%b exp=11", {imem_req, ir_wr}); end
        step();
        imem_ack = 1'b0;
        #1;
        total++; if ({bus_aluSrc, bus_seu, bus_aluOp} !== 6'b100011) begin bad++; $display("FAIL orri_fields got=%b exp=100011", {bus_aluSrc, bus_seu, bus_aluOp}); end
        step();
        step();
        total++; if ({bus_regWr, pc_wr} !== 2'b11) begin bad++; $display("FAIL orri_wb got=%b exp=11", {bus_regWr, pc_wr}); end
        step();
        total++; if (retired !== 3'd7) begin bad++; $display("FAIL orri_retired got=%0d exp=7", retired); end
    endtask

    task automatic test_ignored_ack();
        en = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        total++; if ({imem_req, ir_wr, dmem_req} !== 3'b000) begin bad++; $display("FAIL stray_ack0 got=%b exp=000", {imem_req, ir_wr, dmem_req}); end
        step();
        total++; if ({ir_wr, pc_wr, dmem_req, bus_aluSrc} !== 4'b0000) begin bad++; $display("FAIL stray_ack1 got=%b exp=0000", {ir_wr, pc_wr, dmem_req, bus_aluSrc}); end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        fetch(11'b00010100000);
        step();
        step();
        total++; if (retired !== 3'd0) begin bad++; $display("FAIL wrap_retired got=%0d exp=0", retired); end
        fetch(11'b00010100000);
        step();
        step();
        total++; if (retired !== 3'd1) begin bad++; $display("FAIL post_wrap_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_mid_reset();
        fetch(11'b11111000010);
        step();
        step();
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mr_dreq_before got=%b exp=1", dmem_req); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({dmem_req, imem_req, retired} !== 5'b0) begin bad++; $display("FAIL mr_async got=%b exp=00000", {dmem_req, imem_req, retired}); end
        step();
        rst_n = 1'b1;
        #1;
        total++; if ({dmem_req, imem_req} !== 2'b00) begin bad++; $display("FAIL mr_release got=%b exp=00", {dmem_req, imem_req}); end
        step();
        total++; if ({dmem_req, imem_req, retired} !== 5'b0) begin bad++; $display("FAIL mr_idle got=%b exp=00000", {dmem_req, imem_req, retired}); end
    endtask

    task automatic test_illegal();
        fetch(11'b00000000000);
        step();
`ifdef MCTRL_ILLEGAL_TRAP_EN
        total++; if (pc_wr !== 1'b0) begin bad++; $display("FAIL ill_exec_pc_wr got=%b exp=0", pc_wr); end
        step();
        total++; if ({illegal, retired} !== 4'b1000) begin bad++; $display("FAIL ill_halt got=%b exp=1000", {illegal, retired}); end
        en = 1'b1; imem_ack = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ill_no_req got=%b exp=0", imem_req); end
        step();
        total++; if ({imem_req, ir_wr, illegal} !== 3'b001) begin bad++; $display("FAIL ill_stuck got=%b exp=001", {imem_req, ir_wr, illegal}); end
`else
        total++; if ({pc_wr, bus_pcSrc} !== 2'b10) begin bad++; $display("FAIL nop_exec got=%b exp=10", {pc_wr, bus_pcSrc}); end
        step();
        total++; if ({illegal, retired} !== 4'b0001) begin bad++; $display("FAIL nop_retired got=%b exp=0001", {illegal, retired}); end
        en = 1'b1; imem_ack = 1'b1;
        #1;
        total++; if ({imem_req, ir_wr} !== 2'b11) begin bad++; $display("FAIL nop_refetch got=%b exp=11", {imem_req, ir_wr}); end
`endif
        en = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_ldur();
        test_stur();
        test_branch();
        test_en_drop();
        test_ignored_ack();
        test_wrap();
        test_mid_reset();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
